mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences the single-ported unified instruction/data memory between instruction fetch (F stage) and load/store (M stage). It consumes the M-stage control and data held in the EX/MEM pipeline register and counts a fixed memory latency. It returns fetched instructions and load data, and raises per-stage stall requests to the hazard unit until each access completes.

## Interface
- DATA_WIDTH, 32: address/data width.
- LATENCY, 2: memory read latency in cycles, legal range 1..7.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ReqF  in  1  fetch request for PCF.
- PCF  in  DATA_WIDTH  fetch address.
- AdvanceF  in  1  F/D register loads at this edge; the current fetch is consumed.
- InstrF  out  DATA_WIDTH  fetched instruction, valid while InstrValidF.
- InstrValidF  out  1  InstrF holds the result for the current PCF.
- StallF  out  1  ReqF & ~InstrValidF.
- MemReadM  in  1  M-stage load (ResultSrcM == 2'b01).
- MemWriteM  in  1  M-stage store.
- ALUResultM  in  DATA_WIDTH  data address.
- WriteDataM  in  DATA_WIDTH  store data.
- modeBUM  in  3  byte/half/word mode; passed to memory unchanged.
- AdvanceM  in  1  EX/MEM register loads at this edge; the current M instruction is consumed.
- ReadDataM  out  DATA_WIDTH  load data, valid while DoneM.
- DoneM  out  1  M access complete for the current M instruction.
- StallM  out  1  (MemReadM|MemWriteM) & ~DoneM.
- mem_req, mem_we  out  1 each  issue strobe and write enable.
- mem_addr, mem_wdata  out  DATA_WIDTH each  address and write data.
- mem_mode  out  3  access mode.
- mem_rdata  in  DATA_WIDTH  valid exactly LATENCY cycles after the issue cycle.

## Operation
- States: IDLE, BUSY_F, BUSY_M.
- Issue happens only in IDLE. mem_* outputs are combinational from the grant in that cycle. The memory samples them at the end of that cycle.
- Grant priority in IDLE:
  - Highest: a pending M access, i.e. (MemReadM|MemWriteM) & ~m_done. The M instruction is older.
  - Next: a pending fetch, i.e. ReqF & ~f_done.
- Store grant: single-cycle. DoneM=1 in the issue cycle. State stays IDLE.
- Load grant: state goes to BUSY_M and the down-counter loads LATENCY-1.
- Fetch grant: state goes to BUSY_F and the down-counter loads LATENCY-1.
- Completion cycle (BUSY_x with count==0):
  - mem_rdata passes straight through to ReadDataM/InstrF.
  - DoneM or InstrValidF is 1.
  - Next state is IDLE.
- With LATENCY=1 the BUSY state lasts exactly one cycle.
- Hold registers (m_done/m_data, f_done/f_data):
  - Set on completion if the matching Advance input is 0.
  - While set, DoneM/InstrValidF stay 1 and the outputs come from the hold register.
  - Cleared at the edge where Advance is 1.
  - This prevents re-issuing a completed access while the pipeline is frozen by the other stage.
- When neither requester is pending: mem_req=0 and mem_* outputs are 0.
- Completion and a new issue never share a cycle. The first new issue is the cycle after the completion cycle.

## Timing
- Reset values:
  - state IDLE, counter 0, hold flags 0, hold data 0.
  - All outputs 0 except StallF/StallM, which follow their equations (0 with no requests).
- Load latency: issue in cycle T, DoneM in T+LATENCY. StallM is high from the first M cycle through T+LATENCY-1.
- Fetch latency is identical. Fetch occupancy is LATENCY+1 cycles including the issue cycle.
- Simultaneous requests in IDLE: M is granted and F waits. Worst-case F stall is (LATENCY+1)+LATENCY+1 cycles after ReqF.
- Request withdrawn while BUSY (flush: ReqF or MemReadM drops):
  - The access still completes and the memory port stays occupied.
  - Result is discarded; no DoneM/InstrValidF and no hold.
- rst asserted mid-transaction: return to IDLE next edge. Any in-flight mem_rdata is ignored.
- An Advance input while its stage is not done has no effect on state.

## Configuration
- MEM_WRITE_BUFFER_EN defined: one-entry write buffer.
  - A store presented in M is accepted into the buffer whenever the buffer is empty, in any state. DoneM=1 in that cycle.
  - The buffer drains on the next IDLE cycle with priority above loads and fetch.
  - A store arriving while the buffer is full stalls (StallM=1) until the buffer drains.
- MEM_WRITE_BUFFER_EN undefined: stores issue directly and only in IDLE, as described under Operation.

## Test plan
- Reset, then idle: all mem_* outputs 0, DoneM=0, InstrValidF=0, StallF=0, StallM=0.
- LATENCY=2, ReqF with PCF=0x10 and mem_rdata=0x00500093 at T+2: mem_req in T only; InstrValidF=1 and InstrF=0x00500093 in T+2; StallF high in T and T+1.
- Load at ALUResultM=0x100 and fetch requested in the same IDLE cycle: the load issues first; DoneM with ReadDataM=0xDEADBEEF at T+2; the fetch issues at T+3.
- Store with modeBUM=3'b000, WriteDataM=0xAB, addr 0x200: mem_we=1 and mem_mode=0 in one cycle; DoneM=1 in the same cycle; no stall.
- Load completes while AdvanceM=0 for 3 cycles: DoneM stays 1 and ReadDataM is held; no second mem_req; flag clears after AdvanceM.
- rst asserted in BUSY_M at count 1: next cycle is IDLE, DoneM=0, and the late mem_rdata is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the
// instruction fetch (F) stage and the load/store (M) stage. Only one access
// can be in flight at a time. A down-counter times the fixed read latency.
// Per-stage stall requests go to the hazard unit until each stage's access
// has completed.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   ReqF, PCF, AdvanceF      fetch request/address, F/D register load strobe
//   InstrF, InstrValidF      fetched instruction and its valid flag
//   StallF                   ReqF & ~InstrValidF
//   MemReadM, MemWriteM      M-stage load / store
//   ALUResultM, WriteDataM   data address and store data
//   modeBUM                  byte/half/word mode, forwarded to the memory
//   AdvanceM                 EX/MEM register load strobe
//   ReadDataM, DoneM         load data and M-access-complete flag
//   StallM                   (MemReadM|MemWriteM) & ~DoneM
//   mem_req, mem_we, mem_addr, mem_wdata, mem_mode
//                            memory issue strobe and command, combinational
//   mem_rdata                read data, valid LATENCY cycles after issue
//
// Parameters
//   DATA_WIDTH  address/data width
//   LATENCY     memory read latency in cycles, 1..7
//
// Build option
//   MEM_WRITE_BUFFER_EN  adds a one-entry write buffer. Stores are accepted
//                        into the buffer in any state and drain on the next
//                        IDLE cycle ahead of loads and fetches. Undefined:
//                        stores issue directly from IDLE.
//
// state  | meaning
// IDLE   | port free; at most one access issues this cycle
// BUSY_F | fetch in flight; cnt counts down to the completion cycle
// BUSY_M | load in flight; cnt counts down to the completion cycle

module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqF,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic                  AdvanceF,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic                  InstrValidF,
  output logic                  StallF,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            modeBUM,
  input  logic                  AdvanceM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  DoneM,
  output logic                  StallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_M = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD   = 3'(LATENCY - 1);
  // Instruction fetches are always full-word accesses.
  localparam logic [2:0] FETCH_MODE = 3'b010;

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic                  kill, kill_nxt;
  logic                  m_done, m_done_nxt;
  logic [DATA_WIDTH-1:0] m_data, m_data_nxt;
  logic                  f_done, f_done_nxt;
  logic [DATA_WIDTH-1:0] f_data, f_data_nxt;

  // Completion strobes for this cycle (before any hold register).
  logic                  m_cmp, f_cmp;
  logic [DATA_WIDTH-1:0] m_cmp_data, f_cmp_data;

  logic                  f_pending;

`ifdef MEM_WRITE_BUFFER_EN
  logic                  wb_valid, wb_valid_nxt;
  logic [DATA_WIDTH-1:0] wb_addr, wb_addr_nxt;
  logic [DATA_WIDTH-1:0] wb_data, wb_data_nxt;
  logic [2:0]            wb_mode, wb_mode_nxt;
  logic                  ld_pending;
`else
  logic                  m_pending;
`endif

  assign f_pending = ReqF & ~f_done;
`ifdef MEM_WRITE_BUFFER_EN
  assign ld_pending = MemReadM & ~m_done;
`else
  assign m_pending = (MemReadM | MemWriteM) & ~m_done;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      kill     <= 1'b0;
      m_done   <= 1'b0;
      m_data   <= '0;
      f_done   <= 1'b0;
      f_data   <= '0;
`ifdef MEM_WRITE_BUFFER_EN
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_mode  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      kill     <= kill_nxt;
      m_done   <= m_done_nxt;
      m_data   <= m_data_nxt;
      f_done   <= f_done_nxt;
      f_data   <= f_data_nxt;
`ifdef MEM_WRITE_BUFFER_EN
      wb_valid <= wb_valid_nxt;
      wb_addr  <= wb_addr_nxt;
      wb_data  <= wb_data_nxt;
      wb_mode  <= wb_mode_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    kill_nxt     = kill;
    m_done_nxt   = m_done;
    m_data_nxt   = m_data;
    f_done_nxt   = f_done;
    f_data_nxt   = f_data;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mode     = '0;
    m_cmp        = 1'b0;
    m_cmp_data   = '0;
    f_cmp        = 1'b0;
    f_cmp_data   = '0;
`ifdef MEM_WRITE_BUFFER_EN
    wb_valid_nxt = wb_valid;
    wb_addr_nxt  = wb_addr;
    wb_data_nxt  = wb_data;
    wb_mode_nxt  = wb_mode;
`endif

    // Nothing issues or completes while reset is held, so the memory never
    // sees a request that the reset edge would immediately abandon.
    if (!rst) begin
      if (AdvanceM) m_done_nxt = 1'b0;
      if (AdvanceF) f_done_nxt = 1'b0;

      case (state)
        IDLE: begin
`ifdef MEM_WRITE_BUFFER_EN
          if (wb_valid) begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr     = wb_addr;
            mem_wdata    = wb_data;
            mem_mode     = wb_mode;
            wb_valid_nxt = 1'b0;
          end else if (ld_pending) begin
            mem_req   = 1'b1;
            mem_addr  = ALUResultM;
            mem_mode  = modeBUM;
            state_nxt = BUSY_M;
            cnt_nxt   = CNT_LOAD;
            kill_nxt  = 1'b0;
          end else if (f_pending) begin
            mem_req   = 1'b1;
            mem_addr  = PCF;
            mem_mode  = FETCH_MODE;
            state_nxt = BUSY_F;
            cnt_nxt   = CNT_LOAD;
            kill_nxt  = 1'b0;
          end
`else
          // The M instruction is older than the fetch, so it wins.
          if (m_pending) begin
            mem_req   = 1'b1;
            mem_we    = MemWriteM;
            mem_addr  = ALUResultM;
            mem_wdata = WriteDataM;
            mem_mode  = modeBUM;
            if (MemWriteM) begin
              m_cmp = 1'b1;
            end else begin
              state_nxt = BUSY_M;
              cnt_nxt   = CNT_LOAD;
              kill_nxt  = 1'b0;
            end
          end else if (f_pending) begin
            mem_req   = 1'b1;
            mem_addr  = PCF;
            mem_mode  = FETCH_MODE;
            state_nxt = BUSY_F;
            cnt_nxt   = CNT_LOAD;
            kill_nxt  = 1'b0;
          end
`endif
        end

        // A requester that drops while its access is in flight has been
        // flushed; kill remembers that even if a new request reappears
        // before the data comes back.
        BUSY_M: begin
          if (!MemReadM) kill_nxt = 1'b1;
          if (cnt == 3'd0) begin
            state_nxt = IDLE;
            if (MemReadM && !kill) begin
              m_cmp      = 1'b1;
              m_cmp_data = mem_rdata;
            end
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end

        BUSY_F: begin
          if (!ReqF) kill_nxt = 1'b1;
          if (cnt == 3'd0) begin
            state_nxt = IDLE;
            if (ReqF && !kill) begin
              f_cmp      = 1'b1;
              f_cmp_data = mem_rdata;
            end
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end

        default: state_nxt = IDLE;
      endcase

`ifdef MEM_WRITE_BUFFER_EN
      // Buffer occupancy is the registered flag, so a store that arrives
      // in the drain cycle waits one cycle and then gets in.
      if (MemWriteM && !m_done && !wb_valid) begin
        wb_valid_nxt = 1'b1;
        wb_addr_nxt  = ALUResultM;
        wb_data_nxt  = WriteDataM;
        wb_mode_nxt  = modeBUM;
        m_cmp        = 1'b1;
      end
`endif

      // Keep a finished result while the stage is frozen by the other one,
      // so the access is not issued a second time.
      if (m_cmp && !AdvanceM) begin
        m_done_nxt = 1'b1;
        m_data_nxt = m_cmp_data;
      end
      if (f_cmp && !AdvanceF) begin
        f_done_nxt = 1'b1;
        f_data_nxt = f_cmp_data;
      end
    end
  end

  assign DoneM       = m_done | m_cmp;
  assign ReadDataM   = m_done ? m_data : m_cmp_data;
  assign InstrValidF = f_done | f_cmp;
  assign InstrF      = f_done ? f_data : f_cmp_data;
  assign StallF      = ReqF & ~InstrValidF;
  assign StallM      = (MemReadM | MemWriteM) & ~DoneM;

endmodule
